// File: rtl/wb_group_arbiter_pkg.sv
// rtl/wb_group_arbiter_pkg.sv - shared types and limits for the writeback group arbiter
//
// Purpose: arbitration mode enum, global sizing limits and the packed
//          writeback result record used by the group arbiter and its users.
// Ports:   none (package).
package wb_group_arbiter_pkg;

    localparam int MAX_NUM_UNITS = 8;
    localparam int MAX_IDS       = 16;
    localparam int XLEN          = 32;

    localparam int WB_ID_W   = $clog2(MAX_IDS);
    localparam int WB_UNIT_W = $clog2(MAX_NUM_UNITS);

    typedef enum logic [0:0] {
        WB_ARB_PRIORITY,
        WB_ARB_ROUND_ROBIN
    } wb_arb_mode_t;

    typedef struct packed {
        logic [WB_ID_W-1:0]   id;
        logic [XLEN-1:0]      rd;
        logic [WB_UNIT_W-1:0] unit;
    } wb_arb_result_t;

endpackage

// File: rtl/wb_group_arbiter_rotating_priority_encoder.sv
// rtl/wb_group_arbiter_rotating_priority_encoder.sv - one-hot priority pick starting at a given index
//
// Purpose: grants the first requester found when scanning upward from
//          i_start and wrapping from N-1 back to 0.
// Ports:   i_req   - request vector
//          i_start - index with highest priority this cycle
//          o_grant - one-hot grant (all-zero when no request)
//          o_valid - at least one request was granted
module rotating_priority_encoder #(
    parameter  int N  = 4,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [SW-1:0] i_start,
    output logic [N-1:0]  o_grant,
    output logic          o_valid
);

    // Pass 0 scans indices at or above the start point, pass 1 wraps to the
    // indices below it; the first hit wins.
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int j = 0; j < N; j++) begin
                if (!o_valid && i_req[j] && ((p == 0) == (j >= int'(i_start)))) begin
                    o_grant[j] = 1'b1;
                    o_valid    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_group_arbiter.sv
// rtl/wb_group_arbiter.sv - writeback group arbiter with registered output and backpressure
//
// Purpose: picks one completing unit per cycle (fixed priority or round-robin)
//          and loads its result into a single output register.
//          Optional starvation guard enabled by macro WB_ARB_STARVATION_GUARD_EN.
// Ports:   i_clk, i_rst     - clock, asynchronous active-high reset
//          i_unit_done      - per-unit result pending
//          i_unit_id        - per-unit instruction ID (unit i at [i*ID_W +: ID_W])
//          i_unit_rd        - per-unit result (unit i at [i*DATA_W +: DATA_W])
//          o_unit_ack       - one-hot grant, combinational
//          i_wb_ready       - downstream accepts the output register
//          o_wb_valid/o_wb_id/o_wb_rd/o_wb_unit - registered writeback
module wb_group_arbiter
    import wb_group_arbiter_pkg::*;
#(
    parameter  int           NUM_UNITS    = 5,
    parameter  int           DATA_W       = 32,
    parameter  int           ID_W         = 4,
    parameter  wb_arb_mode_t MODE         = WB_ARB_PRIORITY,
    parameter  int           STARVE_LIMIT = 8,
    localparam int           UNIT_W       = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_UNITS-1:0]        i_unit_done,
    input  logic [NUM_UNITS*ID_W-1:0]   i_unit_id,
    input  logic [NUM_UNITS*DATA_W-1:0] i_unit_rd,
    output logic [NUM_UNITS-1:0]        o_unit_ack,
    input  logic                        i_wb_ready,
    output logic                        o_wb_valid,
    output logic [ID_W-1:0]             o_wb_id,
    output logic [DATA_W-1:0]           o_wb_rd,
    output logic [UNIT_W-1:0]           o_wb_unit
);

    logic                 r_wb_valid;
    logic [ID_W-1:0]      r_wb_id;
    logic [DATA_W-1:0]    r_wb_rd;
    logic [UNIT_W-1:0]    r_wb_unit;
    logic [UNIT_W-1:0]    r_rr_ptr;

    logic                 w_can_load;
    logic [UNIT_W-1:0]    w_start;
    logic [NUM_UNITS-1:0] w_mode_grant;
    logic                 w_mode_valid;
    logic [NUM_UNITS-1:0] w_sel_grant;
    logic                 w_sel_valid;
    logic [NUM_UNITS-1:0] w_ack;
    logic [UNIT_W-1:0]    w_sel_idx;
    logic [UNIT_W-1:0]    w_next_ptr;
    logic [ID_W-1:0]      w_sel_id;
    logic [DATA_W-1:0]    w_sel_rd;

    // The register can take a new result when empty or being drained now.
    assign w_can_load = !r_wb_valid || i_wb_ready;
    assign w_start    = (MODE == WB_ARB_ROUND_ROBIN) ? r_rr_ptr : '0;

    rotating_priority_encoder #(.N(NUM_UNITS)) u_mode_enc (
        .i_req   (i_unit_done),
        .i_start (w_start),
        .o_grant (w_mode_grant),
        .o_valid (w_mode_valid)
    );

`ifdef WB_ARB_STARVATION_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]     r_wait_cnt [NUM_UNITS];
    logic [NUM_UNITS-1:0] w_starved;
    logic [NUM_UNITS-1:0] w_starve_grant;
    logic                 w_starve_valid;

    always_comb begin
        w_starved = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_starved[i] = i_unit_done[i] && (r_wait_cnt[i] == CNT_W'(STARVE_LIMIT));
        end
    end

    // Starved units bypass the mode and are served lowest index first.
    rotating_priority_encoder #(.N(NUM_UNITS)) u_starve_enc (
        .i_req   (w_starved),
        .i_start ('0),
        .o_grant (w_starve_grant),
        .o_valid (w_starve_valid)
    );

    assign w_sel_grant = w_starve_valid ? w_starve_grant : w_mode_grant;
    assign w_sel_valid = w_starve_valid || w_mode_valid;

    // Waiting only counts on cycles where a grant was actually possible.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_UNITS; i++) r_wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (!i_unit_done[i] || w_ack[i]) begin
                    r_wait_cnt[i] <= '0;
                end else if (w_can_load && (r_wait_cnt[i] != CNT_W'(STARVE_LIMIT))) begin
                    r_wait_cnt[i] <= r_wait_cnt[i] + CNT_W'(1);
                end
            end
        end
    end
`else
    assign w_sel_grant = w_mode_grant;
    assign w_sel_valid = w_mode_valid;
`endif

    assign w_ack      = (w_can_load && !i_rst) ? w_sel_grant : '0;
    assign o_unit_ack = w_ack;

    always_comb begin
        w_sel_idx = '0;
        w_sel_id  = '0;
        w_sel_rd  = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (w_sel_grant[i]) begin
                w_sel_idx = UNIT_W'(i);
                w_sel_id  = i_unit_id[i*ID_W +: ID_W];
                w_sel_rd  = i_unit_rd[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_next_ptr = (w_sel_idx == UNIT_W'(NUM_UNITS - 1)) ? '0 : w_sel_idx + UNIT_W'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wb_valid <= 1'b0;
            r_wb_id    <= '0;
            r_wb_rd    <= '0;
            r_wb_unit  <= '0;
            r_rr_ptr   <= '0;
        end else if (w_can_load) begin
            r_wb_valid <= w_sel_valid;
            if (w_sel_valid) begin
                r_wb_id   <= w_sel_id;
                r_wb_rd   <= w_sel_rd;
                r_wb_unit <= w_sel_idx;
                r_rr_ptr  <= w_next_ptr;
            end
        end
    end

    assign o_wb_valid = r_wb_valid;
    assign o_wb_id    = r_wb_id;
    assign o_wb_rd    = r_wb_rd;
    assign o_wb_unit  = r_wb_unit;

`ifndef SYNTHESIS
    a_params: assert property (@(posedge i_clk)
        (STARVE_LIMIT >= 1) && (NUM_UNITS >= 1) && (NUM_UNITS <= MAX_NUM_UNITS));
    a_ack_onehot0: assert property (@(posedge i_clk) disable iff (i_rst)
        $onehot0(o_unit_ack));
    a_ack_needs_done: assert property (@(posedge i_clk) disable iff (i_rst)
        ((o_unit_ack & ~i_unit_done) == '0));
    a_hold_stable: assert property (@(posedge i_clk) disable iff (i_rst)
        (r_wb_valid && !i_wb_ready) |=> ($stable(r_wb_id) && $stable(r_wb_rd)));
`endif

endmodule

// File: tb/tb_wb_group_arbiter.sv
// tb/tb_wb_group_arbiter.sv - self-checking bench for wb_group_arbiter
module tb_wb_group_arbiter;
    import wb_group_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // sel 0: priority, 3 units, starvation limit 4
    logic [2:0]   a_done, a_ack;
    logic [11:0]  a_id;
    logic [95:0]  a_rd;
    logic         a_ready, a_valid;
    logic [3:0]   a_wid;
    logic [31:0]  a_wrd;
    logic [1:0]   a_unit;
    // sel 1: round-robin, 4 units
    logic [3:0]   b_done, b_ack;
    logic [15:0]  b_id;
    logic [127:0] b_rd;
    logic         b_ready, b_valid;
    logic [3:0]   b_wid;
    logic [31:0]  b_wrd;
    logic [1:0]   b_unit;
    // sel 2: single unit
    logic [0:0]   c_done, c_ack;
    logic [3:0]   c_id;
    logic [31:0]  c_rd;
    logic         c_ready, c_valid;
    logic [3:0]   c_wid;
    logic [31:0]  c_wrd;
    logic [0:0]   c_unit;

    wb_group_arbiter #(.NUM_UNITS(3), .DATA_W(32), .ID_W(4), .MODE(WB_ARB_PRIORITY), .STARVE_LIMIT(4)) u_pri (
        .i_clk(clk), .i_rst(rst), .i_unit_done(a_done), .i_unit_id(a_id), .i_unit_rd(a_rd),
        .o_unit_ack(a_ack), .i_wb_ready(a_ready), .o_wb_valid(a_valid), .o_wb_id(a_wid),
        .o_wb_rd(a_wrd), .o_wb_unit(a_unit));

    wb_group_arbiter #(.NUM_UNITS(4), .DATA_W(32), .ID_W(4), .MODE(WB_ARB_ROUND_ROBIN), .STARVE_LIMIT(8)) u_rr (
        .i_clk(clk), .i_rst(rst), .i_unit_done(b_done), .i_unit_id(b_id), .i_unit_rd(b_rd),
        .o_unit_ack(b_ack), .i_wb_ready(b_ready), .o_wb_valid(b_valid), .o_wb_id(b_wid),
        .o_wb_rd(b_wrd), .o_wb_unit(b_unit));

    wb_group_arbiter #(.NUM_UNITS(1), .DATA_W(32), .ID_W(4), .MODE(WB_ARB_PRIORITY), .STARVE_LIMIT(8)) u_one (
        .i_clk(clk), .i_rst(rst), .i_unit_done(c_done), .i_unit_id(c_id), .i_unit_rd(c_rd),
        .o_unit_ack(c_ack), .i_wb_ready(c_ready), .o_wb_valid(c_valid), .o_wb_id(c_wid),
        .o_wb_rd(c_wrd), .o_wb_unit(c_unit));

    typedef struct { int dut; logic [3:0] done; logic ready; logic [3:0] ack; } vec_t;
    typedef struct { wb_arb_result_t res; int due; } sb_t;

    sb_t exp_q[$];
    int  cyc = 0;
    int  sel = 0;
    int  checks = 0;
    int  failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic wb_arb_result_t expect_of(input int s, input int u);
        wb_arb_result_t r;
        r.unit = WB_UNIT_W'(u);
        r.id   = '0;
        r.rd   = '0;
        if (s == 0) begin
            r.id = WB_ID_W'(u + 1);
            r.rd = 32'h100 + 32'(u);
        end else if (s == 1) begin
            case (u)
                0:       begin r.id = 4'd5;  r.rd = 32'hDEADBEEF; end
                1:       begin r.id = 4'd9;  r.rd = 32'h12345678; end
                2:       begin r.id = 4'd3;  r.rd = 32'h0BADF00D; end
                default: begin r.id = 4'd12; r.rd = 32'hCAFEF00D; end
            endcase
        end else begin
            r.id = c_id;
            r.rd = c_rd;
        end
        return r;
    endfunction

    function automatic int oh2idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [3:0] cur_ack();
        case (sel)
            0:       return {1'b0, a_ack};
            1:       return b_ack;
            default: return {3'b000, c_ack};
        endcase
    endfunction

    task automatic drive(input int s, input logic [3:0] done, input logic rdy);
        sel     = s;
        a_done  = (s == 0) ? done[2:0] : 3'b000;
        b_done  = (s == 1) ? done : 4'b0000;
        c_done  = (s == 2) ? done[0:0] : 1'b0;
        a_ready = (s == 0) ? rdy : 1'b1;
        b_ready = (s == 1) ? rdy : 1'b1;
        c_ready = (s == 2) ? rdy : 1'b1;
    endtask

    task automatic push(input int u);
        sb_t e;
        e.res = expect_of(sel, u);
        e.due = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Checks the selected DUT's output register against the scoreboard head.
    task automatic mon();
        logic           v;
        logic           rdy;
        wb_arb_result_t got;
        sb_t            e;
        case (sel)
            0:       begin v = a_valid; rdy = a_ready; got.id = a_wid; got.rd = a_wrd; got.unit = WB_UNIT_W'(a_unit); end
            1:       begin v = b_valid; rdy = b_ready; got.id = b_wid; got.rd = b_wrd; got.unit = WB_UNIT_W'(b_unit); end
            default: begin v = c_valid; rdy = c_ready; got.id = c_wid; got.rd = c_wrd; got.unit = WB_UNIT_W'(c_unit); end
        endcase
        if (exp_q.size() > 0 && exp_q[0].due == cyc) check("wb_valid_latency", v, 1'b1);
        if (v && rdy) begin
            if (exp_q.size() == 0) begin
                check("wb_spurious_valid", v, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("wb_id", got.id, e.res.id);
                check("wb_rd", got.rd, e.res.rd);
                check("wb_unit", got.unit, e.res.unit);
            end
        end
    endtask

    task automatic apply(input vec_t t);
        drive(t.dut, t.done, t.ready);
        @(negedge clk);
        mon();
        check("unit_ack", cur_ack(), t.ack);
        if (t.ack != 4'b0000) push(oh2idx(t.ack));
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t       vecs[$];
        logic [3:0] d;
        logic [3:0] e;

        rst  = 1'b1;
        a_id = {4'd3, 4'd2, 4'd1};
        a_rd = {32'h102, 32'h101, 32'h100};
        b_id = {4'd12, 4'd3, 4'd9, 4'd5};
        b_rd = {32'hCAFEF00D, 32'h0BADF00D, 32'h12345678, 32'hDEADBEEF};
        c_id = 4'd0;
        c_rd = 32'd0;
        a_done = 3'b111; b_done = 4'b1111; c_done = 1'b1;
        a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;

        @(negedge clk);
        check("rst_a_ack", a_ack, 3'b000);
        check("rst_b_ack", b_ack, 4'b0000);
        check("rst_c_ack", c_ack, 1'b0);
        check("rst_a_valid", a_valid, 1'b0);
        check("rst_a_id", a_wid, 4'd0);
        check("rst_a_rd", a_wrd, 32'd0);
        check("rst_a_unit", a_unit, 2'd0);
        check("rst_b_valid", b_valid, 1'b0);
        check("rst_c_valid", c_valid, 1'b0);
        drive(0, 4'b0000, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // priority: units drop done after their ack, then a backpressure hold
        vecs.push_back('{0, 4'b0111, 1'b1, 4'b0001});
        vecs.push_back('{0, 4'b0110, 1'b1, 4'b0010});
        vecs.push_back('{0, 4'b0100, 1'b1, 4'b0100});
        vecs.push_back('{0, 4'b0000, 1'b1, 4'b0000});
        vecs.push_back('{0, 4'b0000, 1'b1, 4'b0000});
        vecs.push_back('{0, 4'b0011, 1'b1, 4'b0001});
        vecs.push_back('{0, 4'b0011, 1'b0, 4'b0000});
        vecs.push_back('{0, 4'b0011, 1'b0, 4'b0000});
        vecs.push_back('{0, 4'b0011, 1'b1, 4'b0001});
        vecs.push_back('{0, 4'b0010, 1'b1, 4'b0010});
        vecs.push_back('{0, 4'b0000, 1'b1, 4'b0000});
        vecs.push_back('{0, 4'b0000, 1'b1, 4'b0000});
        // round-robin: all units re-presenting, grant order 0,1,2,3,0
        vecs.push_back('{1, 4'b1111, 1'b1, 4'b0001});
        vecs.push_back('{1, 4'b1111, 1'b1, 4'b0010});
        vecs.push_back('{1, 4'b1111, 1'b1, 4'b0100});
        vecs.push_back('{1, 4'b1111, 1'b1, 4'b1000});
        vecs.push_back('{1, 4'b1111, 1'b1, 4'b0001});
        vecs.push_back('{1, 4'b0000, 1'b1, 4'b0000});
        vecs.push_back('{1, 4'b0000, 1'b1, 4'b0000});
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // backpressure: rr_ptr is 1, so only unit 0 pending wraps to unit 0
        apply('{1, 4'b0001, 1'b1, 4'b0001});
        for (int k = 0; k < 3; k++) begin
            drive(1, 4'b0010, 1'b0);
            @(negedge clk);
            mon();
            check("bp_ack", b_ack, 4'b0000);
            check("bp_valid", b_valid, 1'b1);
            check("bp_id", b_wid, 4'd5);
            check("bp_rd", b_wrd, 32'hDEADBEEF);
            @(posedge clk);
            #1;
        end
        apply('{1, 4'b0010, 1'b1, 4'b0010});
        apply('{1, 4'b0000, 1'b1, 4'b0000});
        apply('{1, 4'b0000, 1'b1, 4'b0000});

        // reset mid-operation: rr_ptr is 2 beforehand, so units 2,3,0 scan picks 0
        apply('{1, 4'b0011, 1'b1, 4'b0001});
        rst = 1'b1;
        #1;
        check("rst_mid_valid", b_valid, 1'b0);
        check("rst_mid_ack", b_ack, 4'b0000);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply('{1, 4'b0011, 1'b1, 4'b0001});
        apply('{1, 4'b0011, 1'b1, 4'b0010});
        apply('{1, 4'b0000, 1'b1, 4'b0000});
        apply('{1, 4'b0000, 1'b1, 4'b0000});

        // starvation: unit 0 re-presents every cycle, unit 2 waits
        d = 4'b0101;
        for (int k = 1; k <= 6; k++) begin
`ifdef WB_ARB_STARVATION_GUARD_EN
            e = (k == 5) ? 4'b0100 : 4'b0001;
`else
            e = 4'b0001;
`endif
            apply('{0, d, 1'b1, e});
            if (e[2]) d = 4'b0001;
        end
        apply('{0, 4'b0000, 1'b1, 4'b0000});
        apply('{0, 4'b0000, 1'b1, 4'b0000});

        // single unit: ten pulses with ids 0..9
        for (int k = 0; k < 10; k++) begin
            c_id = 4'(k);
            c_rd = 32'hA000_0000 + 32'(k);
            apply('{2, 4'b0001, 1'b1, 4'b0001});
            apply('{2, 4'b0000, 1'b1, 4'b0000});
        end
        apply('{2, 4'b0000, 1'b1, 4'b0000});

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
